// File: rtl/fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
// Default geometry plus the pointer-width helper used by the top.
package fifo_pkg;

   localparam int FIFO_DATA_W = 8;
   localparam int FIFO_DEPTH  = 16;
   localparam int FIFO_AF_TH  = 14;
   localparam int FIFO_AE_TH  = 2;

   typedef logic [FIFO_DATA_W-1:0] data_ty;

   // A depth-2 FIFO still needs one address bit
   function automatic int ptr_w(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port.
// No reset; contents are meaningless until written.
module fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy, thresholds,
// sticky error flags, synchronous flush and optional FWFT output.
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int AF_TH  = FIFO_AF_TH,
   parameter int AE_TH  = FIFO_AE_TH,
   parameter int FWFT   = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   ptr_t              wr_ptr_q, wr_ptr_d;
   ptr_t              rd_ptr_q, rd_ptr_d;
   cnt_t              count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              af_q, af_d;
   logic              ae_q, ae_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              wr_acc, rd_acc, mem_we;
   logic [DATA_W-1:0] mem_rd_data;

   function automatic ptr_t nxt(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rd_data)
   );

   always_comb begin
      // A word written into an empty FIFO is not readable this cycle
      rd_acc   = rd_en & ~empty_q;
      wr_acc   = wr_en & (~full_q | rd_acc);
      mem_we   = wr_acc & ~clr;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      dout_d   = dout_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
         dout_d   = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = nxt(wr_ptr_q);
         end
         if (rd_acc) begin
            rd_ptr_d = nxt(rd_ptr_q);
            dout_d   = mem_rd_data;
         end
         count_d = count_q + cnt_t'(wr_acc) - cnt_t'(rd_acc);
         ovf_d   = ovf_q | (wr_en & ~wr_acc);
         udf_d   = udf_q | (rd_en & ~rd_acc);
      end
      full_d  = (count_d == cnt_t'(DEPTH));
      empty_d = (count_d == '0);
      af_d    = (count_d >= cnt_t'(AF_TH));
      ae_d    = (count_d <= cnt_t'(AE_TH));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         dout_q   <= dout_d;
      end
   end

   assign data_out = (FWFT != 0) ? (empty_q ? '0 : mem_rd_data)
                                 : dout_q;

   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule
